// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
//   - seqState_t : 2-bit state encoding IDLE/LEN/PASS/PAR
//   - DEF_*      : default pattern, pattern length and length-field width
//   - evenParity : XOR reduction used for the optional payload parity check
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    PASS = 2'd2,
    PAR  = 2'd3
  } seqState_t;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1101;
  localparam int         DEF_LEN_W   = 4;

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic evenParity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/seq_payload_counter.sv
// Down-counter holding the number of payload bits still to forward.
// Ports:
//   clk, rst (async, active high)
//   load / loadVal : load a new count (has priority over dec)
//   dec            : decrement by one; ignored when the count is already zero
//   count          : current value
//   isZero         : terminal-count flag
module seq_payload_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         isZero
);

  assign isZero = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && !isZero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/param_seq_detector.sv
// Parametrised serial sequence detector.
// Samples SerIn on clkEN strobes, hunts for PATTERN (MSB first), then reads a
// LEN_W-bit length field (MSB first) and forwards that many payload bits on
// SerOut/SerOutValid.
// Ports:
//   clk, rst (async, active high), clkEN (sample strobe), SerIn
//   SerOut, SerOutValid : registered payload bit and its one-clk valid pulse
//   busy                : frame in progress (length or payload phase)
//   frameDone           : one-clk pulse when the frame completes
//   bitCnt              : payload bits still to forward
//   parityErr           : only with PAYLOAD_PARITY_EN defined; result of the
//                         trailing even-parity bit, valid with frameDone
// Build option: PAYLOAD_PARITY_EN adds the PAR state and the parityErr port.
//
// state | meaning
// IDLE  | shifting SerIn, hunting for the start pattern
// LEN   | capturing the in-band length field, MSB first
// PASS  | forwarding payload bits, bitCnt counting down
// PAR   | receiving the trailing parity bit (PAYLOAD_PARITY_EN only)
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 LEN_W   = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEN,
  input  logic             SerIn,
  output logic             SerOut,
  output logic             SerOutValid,
  output logic             busy,
  output logic             frameDone,
  output logic [LEN_W-1:0] bitCnt
`ifdef PAYLOAD_PARITY_EN
  ,
  output logic             parityErr
`endif
);

  localparam int HIST_W = $clog2(PAT_LEN + 1);
  localparam int IDX_W  = $clog2(LEN_W + 1);

  seqState_t          state, stateNext;
  logic [PAT_LEN-1:0] shreg, shregNext, shiftIn;
  logic [HIST_W-1:0]  histCnt, histNext;
  logic [IDX_W-1:0]   lenIdx, lenIdxNext;
  logic [LEN_W-1:0]   lenReg, lenRegNext, lenShift;
  logic               parAcc, parAccNext;
  logic               serOutNext, validNext, doneNext;
  logic               cntLoad, cntDec, cntZero;
  logic               match;
`ifdef PAYLOAD_PARITY_EN
  logic               parityErrNext;
`endif

  seq_payload_counter #(.W(LEN_W)) uCounter (
    .clk     (clk),
    .rst     (rst),
    .load    (cntLoad),
    .loadVal (lenShift),
    .dec     (cntDec),
    .count   (bitCnt),
    .isZero  (cntZero)
  );

  assign shiftIn  = PAT_LEN'({shreg, SerIn});
  assign lenShift = LEN_W'({lenReg, SerIn});
  // Pattern only counts once the history (including this bit) is full, so a
  // cleared shift register can never fake a match on an all-zero pattern.
  assign match    = (histCnt >= HIST_W'(PAT_LEN - 1)) && (shiftIn == PATTERN);

  always_comb begin
    stateNext  = state;
    shregNext  = shreg;
    histNext   = histCnt;
    lenIdxNext = lenIdx;
    lenRegNext = lenReg;
    parAccNext = parAcc;
    serOutNext = SerOut;
    validNext  = 1'b0;
    doneNext   = 1'b0;
    cntLoad    = 1'b0;
    cntDec     = 1'b0;
`ifdef PAYLOAD_PARITY_EN
    parityErrNext = parityErr;
`endif
    if (clkEN) begin
      case (state)
        IDLE: begin
          shregNext = shiftIn;
          if (histCnt != HIST_W'(PAT_LEN)) histNext = histCnt + 1'b1;
          if (match) begin
            stateNext  = LEN;
            lenIdxNext = '0;
            lenRegNext = '0;
          end
        end
        LEN: begin
          lenRegNext = lenShift;
          lenIdxNext = lenIdx + 1'b1;
          if (lenIdx == IDX_W'(LEN_W - 1)) begin
            parAccNext = evenParity(32'(lenShift));
            if (lenShift == '0) begin
`ifdef PAYLOAD_PARITY_EN
              stateNext = PAR;
`else
              doneNext  = 1'b1;
              stateNext = IDLE;
              shregNext = '0;
              histNext  = '0;
`endif
            end else begin
              cntLoad   = 1'b1;
              stateNext = PASS;
            end
          end
        end
        PASS: begin
          serOutNext = SerIn;
          validNext  = 1'b1;
          cntDec     = !cntZero;
          parAccNext = parAcc ^ SerIn;
          if (bitCnt == LEN_W'(1)) begin
`ifdef PAYLOAD_PARITY_EN
            stateNext = PAR;
`else
            doneNext  = 1'b1;
            stateNext = IDLE;
            shregNext = '0;
            histNext  = '0;
`endif
          end
        end
`ifdef PAYLOAD_PARITY_EN
        PAR: begin
          parityErrNext = SerIn ^ parAcc;
          doneNext      = 1'b1;
          stateNext     = IDLE;
          shregNext     = '0;
          histNext      = '0;
        end
`endif
        default: begin
          stateNext = IDLE;
          shregNext = '0;
          histNext  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      histCnt     <= '0;
      lenIdx      <= '0;
      lenReg      <= '0;
      parAcc      <= 1'b0;
      SerOut      <= 1'b0;
      SerOutValid <= 1'b0;
      frameDone   <= 1'b0;
      busy        <= 1'b0;
`ifdef PAYLOAD_PARITY_EN
      parityErr   <= 1'b0;
`endif
    end else begin
      state       <= stateNext;
      shreg       <= shregNext;
      histCnt     <= histNext;
      lenIdx      <= lenIdxNext;
      lenReg      <= lenRegNext;
      parAcc      <= parAccNext;
      SerOut      <= serOutNext;
      SerOutValid <= validNext;
      frameDone   <= doneNext;
      busy        <= (stateNext != IDLE);
`ifdef PAYLOAD_PARITY_EN
      parityErr   <= parityErrNext;
`endif
    end
  end

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench for param_seq_detector: a bit-level reference model queues
// expected output events tagged with the strobe that produces them; a negedge
// monitor pops and compares whenever the DUT presents an output.
module tb_param_seq_detector;

  localparam int         PAT_LEN = 4;
  localparam logic [3:0] PATTERN = 4'b1101;
  localparam int         LEN_W   = 4;

  logic clk = 1'b0;
  logic rst, clkEN, SerIn;
  logic SerOut, SerOutValid, busy, frameDone;
  logic [LEN_W-1:0] bitCnt;
`ifdef PAYLOAD_PARITY_EN
  logic parityErr;
`endif

  always #5 clk = ~clk;

  param_seq_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .clkEN       (clkEN),
    .SerIn       (SerIn),
    .SerOut      (SerOut),
    .SerOutValid (SerOutValid),
    .busy        (busy),
    .frameDone   (frameDone),
    .bitCnt      (bitCnt)
`ifdef PAYLOAD_PARITY_EN
    ,
    .parityErr   (parityErr)
`endif
  );

  typedef struct { int idx; bit b; int cnt; } outEv_t;
  typedef struct { int idx; bit perr; } doneEv_t;

  outEv_t  expOut[$];
  doneEv_t expDone[$];
  int checks = 0;
  int failures = 0;
  int doneCount = 0;
  int sIdx = 0;
  bit lastStrobe = 1'b0;

  // Reference model: mode 0 hunt, 1 length, 2 payload, 3 parity bit
  int mode = 0;
  bit hist[$];
  int lenVal, lenBits, remaining;
  bit parAcc;

  task automatic check(input string name, input int act, input int expV);
    checks++;
    if (act !== expV) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expV, $time);
    end
  endtask

  function automatic void resetModel();
    mode = 0;
    hist.delete();
    remaining = 0;
    lenVal = 0;
    lenBits = 0;
    parAcc = 1'b0;
    expOut.delete();
    expDone.delete();
    lastStrobe = 1'b0;
  endfunction

  function automatic void endFrame();
`ifdef PAYLOAD_PARITY_EN
    mode = 3;
`else
    expDone.push_back('{sIdx, 1'b0});
    mode = 0;
`endif
  endfunction

  function automatic void modelStep(input bit b);
    int v;
    sIdx++;
    case (mode)
      0: begin
        hist.push_back(b);
        if (hist.size() > PAT_LEN) void'(hist.pop_front());
        if (hist.size() == PAT_LEN) begin
          v = 0;
          foreach (hist[i]) v = v * 2 + int'(hist[i]);
          if (v == int'(PATTERN)) begin
            mode = 1;
            lenVal = 0;
            lenBits = 0;
            parAcc = 1'b0;
            hist.delete();
          end
        end
      end
      1: begin
        lenVal = lenVal * 2 + int'(b);
        lenBits++;
        parAcc ^= b;
        if (lenBits == LEN_W) begin
          if (lenVal == 0) endFrame();
          else begin
            remaining = lenVal;
            mode = 2;
          end
        end
      end
      2: begin
        remaining--;
        parAcc ^= b;
        expOut.push_back('{sIdx, b, remaining});
        if (remaining == 0) endFrame();
      end
      default: begin
        expDone.push_back('{sIdx, b ^ parAcc});
        mode = 0;
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) lastStrobe = 1'b0;
    else if (clkEN) begin
      lastStrobe = 1'b1;
      modelStep(SerIn);
    end else lastStrobe = 1'b0;
  end

  // Monitor
  always @(negedge clk) begin
    bit expV, expD;
    outEv_t e;
    doneEv_t d;
    check("busy", int'(busy), (mode != 0) ? 1 : 0);
    check("bitCnt", int'(bitCnt), (mode == 2) ? remaining : 0);
    expV = lastStrobe && expOut.size() > 0 && expOut[0].idx == sIdx;
    check("serOutValid", int'(SerOutValid), int'(expV));
    if (expV) begin
      e = expOut.pop_front();
      if (SerOutValid) check("serOut", int'(SerOut), int'(e.b));
    end
    expD = lastStrobe && expDone.size() > 0 && expDone[0].idx == sIdx;
    check("frameDone", int'(frameDone), int'(expD));
    if (frameDone) doneCount++;
    if (expD) begin
      d = expDone.pop_front();
`ifdef PAYLOAD_PARITY_EN
      if (frameDone) check("parityErr", int'(parityErr), int'(d.perr));
`endif
    end
  end

  task automatic sendBit(input bit b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      clkEN = 1'b0;
      SerIn = 1'($urandom);
    end
    @(negedge clk);
    clkEN = 1'b1;
    SerIn = b;
  endtask

  task automatic sendBits(input logic [31:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) sendBit(v[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clkEN = 1'b0;
      SerIn = 1'($urandom);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_SerOut"}, int'(SerOut), 0);
    check({tag, "_SerOutValid"}, int'(SerOutValid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frameDone"}, int'(frameDone), 0);
    check({tag, "_bitCnt"}, int'(bitCnt), 0);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    clkEN = 1'b0;
    SerIn = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    #1 checkAllZero("reset");
    rst = 1'b0;
    idle(2);

    // Basic frame: 1101, length 3, payload 101
    d0 = doneCount;
    sendBits(32'b1101_0011_101, 11, 0);
    idle(4);
    check("basicDone", doneCount - d0, 1);

    // Overlapping start, then a false start that must not match
    d0 = doneCount;
    sendBits(32'b11101, 5, 0);
    sendBits(32'b0011_101, 7, 0);
    sendBits(32'b1100_0000, 8, 0);
    idle(4);
    check("overlapDone", doneCount - d0, 1);

    // Zero-length frame
    d0 = doneCount;
    sendBits(32'b1101_0000, 8, 0);
    idle(3);
    check("zeroLenDone", doneCount - d0, 1);

    // Gapped strobes with junk between them
    d0 = doneCount;
    sendBits(32'b1101_0011_101, 11, 3);
    idle(6);
    check("gappedDone", doneCount - d0, 1);

    // Reset in the middle of a length-5 frame
    d0 = doneCount;
    sendBits(32'b1101_0101, 8, 0);
    @(negedge clk);
    clkEN = 1'b0;
    #1 check("preResetBitCnt", int'(bitCnt), 5);
    check("preResetBusy", int'(busy), 1);
    #1 rst = 1'b1;
    resetModel();
    #1 checkAllZero("midReset");
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    check("noDoneOnReset", doneCount - d0, 0);
    sendBits(32'b1101_0010_11, 10, 0);
    idle(4);
    check("afterResetDone", doneCount - d0, 1);

`ifdef PAYLOAD_PARITY_EN
    sendBits(32'b1101_0011_101_0, 12, 0);
    @(negedge clk);
    clkEN = 1'b0;
    #1 check("parityGood", int'(parityErr), 0);
    sendBits(32'b1101_0011_101_1, 12, 0);
    @(negedge clk);
    clkEN = 1'b0;
    #1 check("parityBad", int'(parityErr), 1);
    idle(3);
`endif

    // Random stream with random strobe gaps
    for (int i = 0; i < 1500; i++) begin
      sendBit(1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    idle(4);
    check("outQueueEmpty", expOut.size(), 0);
    check("doneQueueEmpty", expDone.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Parametrised successor of the fixed serial sequence detector.
- Samples a serial stream on clkEN strobes and searches for a programmable start pattern.
- After a match, captures an in-band length field, then forwards that many payload bits on SerOut/SerOutValid.
- Payload counter is internal, so no external counter handshake is needed. Sits between the serial line front-end and the downstream deserializer.

Parameters:
- PAT_LEN, 4, start-pattern length in bits (2..16)
- PATTERN, 4'b1101, start pattern, MSB received first, width PAT_LEN
- LEN_W, 4, width of the in-band payload-length field (payload 0..2^LEN_W-1 bits)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clkEN  in  1  sample strobe; SerIn is consumed only on posedges where clkEN=1
- SerIn  in  1  serial data in
- SerOut  out  1  forwarded payload bit
- SerOutValid  out  1  one-clk pulse: SerOut holds a payload bit
- busy  out  1  high in LEN/PASS states
- frameDone  out  1  one-clk pulse after the last payload bit (or on zero-length frame)
- bitCnt  out  LEN_W  payload bits still to forward

Behaviour:
- Reset (async, rst=1): state=IDLE, shift register=0, history-valid count=0, SerOut=0, SerOutValid=0, busy=0, frameDone=0, bitCnt=0. rst mid-frame aborts immediately; no frameDone.
- All state/data updates occur only on posedge clk with clkEN=1. Exception: SerOutValid and frameDone clear on every posedge where they are not re-asserted.
- IDLE: shift SerIn into PAT_LEN-bit shift register (LSB = newest). Match requires at least PAT_LEN bits sampled since reset or frame end, and shreg equal to PATTERN after the shift. Overlapping matches are allowed. Match -> LEN, length capture index=0.
- LEN: capture LEN_W bits MSB first. On the last length bit:
  - length=0 -> frameDone=1, go to IDLE.
  - otherwise bitCnt=length, go to PASS.
- PASS: each strobe: SerOut<=SerIn, SerOutValid<=1, bitCnt<=bitCnt-1. When bitCnt reaches 0 -> frameDone=1 same edge, go to IDLE.
- Latency: SerOut/SerOutValid valid one clk after the sampling edge, i.e. registered, visible in the cycle following the strobe.
- Exit to IDLE clears the shift register and the history count. Pattern bits cannot straddle frames.
- clkEN held high continuously: one bit per clk, no bubbles required.
- bitCnt never wraps. Decrement occurs only in PASS with bitCnt>0.
- busy = (state==LEN || state==PASS), registered.

Optional Feature:
- Macro PAYLOAD_PARITY_EN.
- Defined: adds state PAR after PASS (and after a zero-length LEN). One extra strobed bit is received and compared against even parity over length field + payload. Adds output parityErr (1 bit, reset 0), registered and valid with frameDone. frameDone is deferred to the parity-bit edge.
- Undefined: no PAR state, no parityErr port, behaviour as above.

Decomposition:
- Shared package seq_det_pkg holds:
  - state encoding constants IDLE/LEN/PASS/PAR (2-bit)
  - default PATTERN/PAT_LEN/LEN_W localparams
  - parity helper function
- Sub-module seq_payload_counter (LEN_W wide): load, decrement on enable, zero flag. It replaces the external inc_cnt/rst_cnt/cout handshake.

Test Plan:
- Reset mid-PASS: assert rst with bitCnt=5 -> all outputs 0 within the same cycle; after release, pattern 1101 is re-detected from scratch.
- Basic frame: strobed SerIn 1,1,0,1, length 0,0,1,1, payload 1,0,1 -> three SerOutValid pulses with SerOut 1,0,1; bitCnt 3,2,1,0; frameDone on the third payload edge; busy low afterwards.
- Overlap/false start: stream 1,1,1,0,1 -> match on the 5th bit only; stream 1,1,0 then reset-free 0 -> no match.
- Zero length: 1101 then 0000 -> frameDone one clk after the last length bit, no SerOutValid, return to IDLE.
- Gapped strobes: same frame as the basic test with clkEN high one clk in every 4 and SerIn toggling between strobes -> identical output sequence; non-strobed values ignored.
- PAYLOAD_PARITY_EN: length 0011, payload 101, parity bit 0 -> parityErr=0; parity bit 1 -> parityErr=1, asserted with frameDone.
